// File: rtl/power_seq_ctrl.sv
// Board power sequencer: enables SoC rails in order, checks power-good, then releases SoC reset.
// Optional automatic retry after the first fault is enabled by defining PWR_SEQ_RETRY_EN.
module power_seq_ctrl #(
    parameter int unsigned NUM_RAILS  = 4,
    parameter logic [23:0] PG_TIMEOUT = 24'd500000,
    parameter logic [23:0] RAIL_DLY   = 24'd100000,
    parameter logic [23:0] RST_DLY    = 24'd1000000
`ifdef PWR_SEQ_RETRY_EN
    ,
    parameter logic [23:0] RETRY_DLY  = 24'd2000000
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pwr_req,
    input  logic [NUM_RAILS-1:0] rail_pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 sys_rst_n,
    output logic                 pwr_fault,
    output logic [2:0]           seq_state
);

    localparam int unsigned CNT_W = 24;
    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_RAILS - 1);
    localparam logic [NUM_RAILS-1:0] RAIL0    = NUM_RAILS'(1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_WAIT_PG  = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_RST_HOLD = 3'd3,
        ST_ON       = 3'd4,
        ST_SHUTDOWN = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [NUM_RAILS-1:0] en_d;
    logic                 rst_n_d;
    logic                 fault_d;
    logic [NUM_RAILS-1:0] cur_mask;
    logic [NUM_RAILS-1:0] good_mask;
    logic                 pg_cur;
    logic                 monitored;
    logic                 pg_lost;
`ifdef PWR_SEQ_RETRY_EN
    logic                 retry_q, retry_d;
`endif

    // Rails that have already reported power-good and must stay good.
    always_comb begin
        good_mask = '0;
        for (int unsigned j = 0; j < NUM_RAILS; j++) begin
            if ((IDX_W'(j) < idx_q) || ((IDX_W'(j) == idx_q) && (state_q != ST_WAIT_PG)))
                good_mask[j] = 1'b1;
        end
    end

    assign cur_mask  = RAIL0 << idx_q;
    assign pg_cur    = |(rail_pg & cur_mask);
    assign monitored = (state_q == ST_WAIT_PG) || (state_q == ST_SETTLE) ||
                       (state_q == ST_RST_HOLD) || (state_q == ST_ON);
    assign pg_lost   = monitored && (|(good_mask & rail_en & ~rail_pg));
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and next-output logic; fault beats power-off beats progress.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_inc;
        en_d    = rail_en;
        rst_n_d = sys_rst_n;
        fault_d = pwr_fault;
`ifdef PWR_SEQ_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            ST_OFF: begin
                en_d    = '0;
                rst_n_d = 1'b0;
                idx_d   = '0;
`ifdef PWR_SEQ_RETRY_EN
                retry_d = 1'b0;
`endif
                if (pwr_req) begin
                    en_d    = RAIL0;
                    state_d = ST_WAIT_PG;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_PG, ST_SETTLE, ST_RST_HOLD, ST_ON: begin
                if (pg_lost) begin
                    state_d = ST_FAULT;
                    en_d    = '0;
                    rst_n_d = 1'b0;
                    fault_d = 1'b1;
                    cnt_d   = '0;
                end else if (!pwr_req) begin
                    state_d = ST_SHUTDOWN;
                    rst_n_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    case (state_q)
                        ST_WAIT_PG: begin
                            // Power-good arriving on the timeout cycle still counts as success.
                            if (pg_cur) begin
                                state_d = ST_SETTLE;
                                cnt_d   = '0;
                            end else if (cnt_q == PG_TIMEOUT - CNT_W'(1)) begin
                                state_d = ST_FAULT;
                                en_d    = '0;
                                rst_n_d = 1'b0;
                                fault_d = 1'b1;
                                cnt_d   = '0;
                            end
                        end
                        ST_SETTLE: begin
                            if (cnt_q == RAIL_DLY - CNT_W'(1)) begin
                                cnt_d = '0;
                                if (idx_q == LAST_IDX) begin
                                    state_d = ST_RST_HOLD;
                                end else begin
                                    idx_d   = idx_q + IDX_W'(1);
                                    en_d    = rail_en | (RAIL0 << (idx_q + IDX_W'(1)));
                                    state_d = ST_WAIT_PG;
                                end
                            end
                        end
                        ST_RST_HOLD: begin
                            if (cnt_q == RST_DLY - CNT_W'(1)) begin
                                rst_n_d = 1'b1;
                                state_d = ST_ON;
                                cnt_d   = '0;
`ifdef PWR_SEQ_RETRY_EN
                                retry_d = 1'b0;
                                fault_d = 1'b0;
`endif
                            end
                        end
                        default: begin
                            rst_n_d = 1'b1;
                        end
                    endcase
                end
            end

            // Drop rails highest-first, one every RAIL_DLY cycles.
            ST_SHUTDOWN: begin
                rst_n_d = 1'b0;
                if (cnt_q == RAIL_DLY - CNT_W'(1)) begin
                    en_d  = rail_en & ~cur_mask;
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end

            ST_FAULT: begin
                en_d    = '0;
                rst_n_d = 1'b0;
                if (!pwr_req) begin
                    state_d = ST_OFF;
                    fault_d = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
`ifdef PWR_SEQ_RETRY_EN
                else if (!retry_q && (cnt_q == RETRY_DLY - CNT_W'(1))) begin
                    state_d = ST_WAIT_PG;
                    en_d    = RAIL0;
                    idx_d   = '0;
                    retry_d = 1'b1;
                    cnt_d   = '0;
                end
`endif
            end

            default: begin
                state_d = ST_OFF;
                en_d    = '0;
                rst_n_d = 1'b0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_OFF;
            idx_q     <= '0;
            cnt_q     <= '0;
            rail_en   <= '0;
            sys_rst_n <= 1'b0;
            pwr_fault <= 1'b0;
`ifdef PWR_SEQ_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rail_en   <= en_d;
            sys_rst_n <= rst_n_d;
            pwr_fault <= fault_d;
`ifdef PWR_SEQ_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign seq_state = state_q;

endmodule
